// File: rtl/raw_byte_packer.sv
// Packs the decrypt stage's byte strobe into 32-bit words, buffers them in a word FIFO
// and tracks frame completion/overflow. Define RAW_BYTE_PACKER_LSB_FIRST_EN for little-endian lane order.
module raw_byte_packer #(
  parameter int unsigned FRAME_BYTES = 1024,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic        en,
  input  logic [7:0]  raw_data,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_done,
  output logic        overflow,
  output logic [15:0] byte_cnt,
  output logic        busy
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_BYTES);
  localparam logic [AW:0] FIFO_FULL  = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_PAD     = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]    state;
  logic [31:0]   pack;
  logic [1:0]    lane_idx;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        start_arm;
  logic        accept;
  logic        pop;
  logic        full;
  logic        push;
  logic        push_ok;
  logic        drop;
  logic        frame_end;
  logic        last_xfer;
  logic [15:0] cnt_inc;
  logic [31:0] pack_next;
  logic [31:0] push_word;

  function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
`ifdef RAW_BYTE_PACKER_LSB_FIRST_EN
    r[{lane, 3'b000} +: 8] = b;
`else
    r[{~lane, 3'b000} +: 8] = b;
`endif
    return r;
  endfunction

  // Lanes at or above the current lane index were never written this word.
  function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [1:0] lane);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(lane)) r = put_lane(r, 2'(i), PAD_BYTE);
    end
    return r;
  endfunction

  assign start_arm  = (state == S_IDLE) && start;
  assign accept     = (state == S_COLLECT) && en;
  assign word_valid = (count != '0);
  assign word_data  = word_valid ? mem[rd_ptr] : 32'h0;
  assign pop        = word_valid && word_ready;
  assign full       = (count == FIFO_FULL);
  assign pack_next  = put_lane(pack, lane_idx, raw_data);
  assign cnt_inc    = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
  assign frame_end  = accept && (cnt_inc == FRAME_LAST);
  assign busy       = (state != S_IDLE);

  always_comb begin
    push      = 1'b0;
    push_word = pack_next;
    if (accept && (lane_idx == 2'd3)) begin
      push = 1'b1;
    end else if ((state == S_PAD) && (lane_idx != 2'd0)) begin
      push      = 1'b1;
      push_word = pad_word(pack, lane_idx);
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign last_xfer = (count == '0) || ((count == (AW+1)'(1)) && pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pack       <= 32'h0;
      lane_idx   <= 2'd0;
      byte_cnt   <= 16'h0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == S_DRAIN) && last_xfer;
      if (drop) overflow <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_COLLECT;
            pack     <= 32'h0;
            lane_idx <= 2'd0;
            byte_cnt <= 16'h0;
            overflow <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            pack     <= (lane_idx == 2'd3) ? 32'h0 : pack_next;
            lane_idx <= lane_idx + 2'd1;
            byte_cnt <= cnt_inc;
          end
          if (frame_end || flush) state <= S_PAD;
        end
        S_PAD: begin
          state    <= S_DRAIN;
          pack     <= 32'h0;
          lane_idx <= 2'd0;
        end
        S_DRAIN: begin
          if (last_xfer) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= 32'h0;
    end else if (start_arm) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_raw_byte_packer.sv
// Scoreboard bench for raw_byte_packer: a byte-list frame model predicts words, a monitor checks transfers.
module tb_raw_byte_packer;
  localparam int FB    = 38;
  localparam int DEPTH = 8;

  logic        clk = 0;
  logic        rst_n = 1;
  logic        start = 0;
  logic        flush = 0;
  logic        en = 0;
  logic [7:0]  raw_data = 0;
  logic        word_ready = 0;
  logic [31:0] word_data;
  logic        word_valid;
  logic        frame_done;
  logic        overflow;
  logic [15:0] byte_cnt;
  logic        busy;

  raw_byte_packer #(.FRAME_BYTES(FB), .FIFO_DEPTH(DEPTH), .PAD_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .en(en), .raw_data(raw_data),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .frame_done(frame_done), .overflow(overflow), .byte_cnt(byte_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  pend[$];
  int mcnt = 0;
  bit armed = 0;
  int hold_limit = -1;
  int frame_words = 0;
  bit rr_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) done_cnt++;
      if (word_valid && word_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h expected none", word_data);
        end else begin
          check("word", word_data, exp_q.pop_front());
        end
      end
    end
  end

  // Frame model: bytes gather into groups of four; a frame end pads any remainder.
  task automatic model_word();
    logic [31:0] w;
    logic [7:0]  b;
    if (pend.size() == 0) return;
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      b = (i < pend.size()) ? pend[i] : 8'h00;
`ifdef RAW_BYTE_PACKER_LSB_FIRST_EN
      w = w | (32'(b) << (8 * i));
`else
      w = {w[23:0], b};
`endif
    end
    if (hold_limit < 0 || frame_words < hold_limit) exp_q.push_back(w);
    frame_words++;
    pend.delete();
  endtask

  task automatic model_end();
    if (!armed) return;
    model_word();
    armed = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!armed) return;
    if (mcnt < 65535) mcnt++;
    pend.push_back(b);
    if (pend.size() == 4) model_word();
    if (mcnt == FB) model_end();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rr_mode) word_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_start();
    start = 1;
    armed = 1;
    mcnt = 0;
    frame_words = 0;
    pend.delete();
    tick();
    start = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit fl);
    en = 1;
    raw_data = b;
    flush = fl;
    model_byte(b);
    if (fl) model_end();
    tick();
    en = 0;
    flush = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    model_end();
    tick();
    flush = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got busy=1 expected busy=0");
    end
    tick();
    tick();
    exp_done++;
    check("frame_done_count", done_cnt, exp_done);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0, n;
    bit fl;
    logic [31:0] head;
    #3 rst_n = 0;
    #2;
    check("rst_word_data", word_data, 0);
    check("rst_word_valid", word_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1;
    tick();

    // Four bytes, latency and packing order
    word_ready = 1;
    do_start();
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    en = 1;
    raw_data = 8'h44;
    model_byte(8'h44);
    @(negedge clk);
    check("latency_before", word_valid, 0);
    @(posedge clk);
    #1 en = 0;
    @(negedge clk);
    check("latency_after", word_valid, 1);
`ifdef RAW_BYTE_PACKER_LSB_FIRST_EN
    check("word_11223344", word_data, 32'h44332211);
`else
    check("word_11223344", word_data, 32'h11223344);
`endif
    @(posedge clk);
    #1;
    check("byte_cnt_4", byte_cnt, 4);
    do_flush();
    wait_idle();

    // Full frame with a partial final word
    do_start();
    for (int i = 0; i < FB; i++) begin
      if ($urandom_range(0, 2) == 0) tick();
      send(8'($urandom), 0);
    end
    check("byte_cnt_frame", byte_cnt, FB);
    wait_idle();

    // Overflow with the stream stalled
    word_ready = 0;
    hold_limit = DEPTH;
    do_start();
    for (int i = 0; i < 4 * (DEPTH + 1); i++) send(8'($urandom), 0);
    check("ovf_flag", overflow, 1);
    check("ovf_byte_cnt", byte_cnt, 4 * (DEPTH + 1));
    check("ovf_valid", word_valid, 1);
    head = exp_q[0];
    check("ovf_head", word_data, head);
    tick();
    tick();
    check("ovf_head_stable", word_data, head);
    do_flush();
    p0 = pops;
    word_ready = 1;
    wait_idle();
    check("ovf_drain_count", pops - p0, DEPTH);
    check("ovf_sticky", overflow, 1);
    hold_limit = -1;

    // Flush with a partial word, bytes after the frame end ignored
    word_ready = 0;
    do_start();
    check("ovf_cleared", overflow, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    do_flush();
    send(8'h03, 0);
    send(8'h04, 0);
    check("flush_byte_cnt", byte_cnt, 2);
`ifdef RAW_BYTE_PACKER_LSB_FIRST_EN
    check("flush_word", word_data, 32'h00000201);
`else
    check("flush_word", word_data, 32'h01020000);
`endif
    word_ready = 1;
    wait_idle();

    // Reset in the middle of a frame
    do_start();
    send(8'h5A, 0);
    send(8'h6B, 0);
    send(8'h7C, 0);
    d0 = done_cnt;
    rst_n = 0;
    armed = 0;
    pend.delete();
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_byte_cnt", byte_cnt, 0);
    check("mid_rst_valid", word_valid, 0);
    check("mid_rst_data", word_data, 0);
    tick();
    tick();
    rst_n = 1;
    tick();
    check("mid_rst_no_done", done_cnt, d0);
    do_start();
    send(8'hAA, 0);
    send(8'hBB, 0);
    send(8'hCC, 0);
    send(8'hDD, 0);
    do_flush();
    wait_idle();

    // Randomized frames with random stalls, flushes and byte gaps
    rr_mode = 1;
    for (int f = 0; f < 8; f++) begin
      do_start();
      n = $urandom_range(1, 50);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 0) tick();
        fl = (i == n - 1) && ($urandom_range(0, 1) == 1);
        send(8'($urandom), fl);
      end
      if (armed) do_flush();
      wait_idle();
      check("rand_byte_cnt", byte_cnt, mcnt);
      check("rand_no_overflow", overflow, 0);
    end
    rr_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/raw_byte_packer.md
Name: raw_byte_packer

Overview:
- Consumes the single-cycle byte strobe (`en`, `raw_data[7:0]`) produced by the decrypt/bit-extract stage.
- Packs consecutive bytes into 32-bit words and buffers them in a small FIFO.
- Presents words on a valid/ready stream to the downstream writer (bitstream/config loader).
- Tracks a frame of FRAME_BYTES bytes and reports completion and overflow.

Parameters:
- FRAME_BYTES, 1024: bytes per frame; legal range 1..65535, need not be a multiple of 4.
- FIFO_DEPTH, 8: word FIFO entries; power of 2, at least 2.
- PAD_BYTE, 8'h00: fill value for the unused lanes of a final partial word.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms a new frame.
- flush  in  1  one-cycle pulse; ends the frame early and emits any partial word.
- en  in  1  byte strobe from the upstream stage.
- raw_data  in  8  byte qualified by `en`.
- word_data  out  32  FIFO head word.
- word_valid  out  1  FIFO non-empty.
- word_ready  in  1  downstream accept; a transfer occurs when `word_valid & word_ready`.
- frame_done  out  1  one-cycle pulse when the frame is fully drained.
- overflow  out  1  sticky flag: a word was dropped because the FIFO was full.
- byte_cnt  out  16  bytes accepted in the current frame.
- busy  out  1  state is not IDLE.

Behaviour:
- Clocking and reset: one clock `clk`. Reset is asynchronous, active-low `rst_n`. All flops clear on reset.
- Reset values: `word_data`=0, `word_valid`=0, `frame_done`=0, `overflow`=0, `byte_cnt`=0, `busy`=0. State=IDLE, FIFO empty, pack register=0, lane index=0.
- States:
  - IDLE: `en` ignored. `start` -> COLLECT, clears `byte_cnt`, lane index, `overflow`, and the FIFO.
  - COLLECT:
    - Each `en` writes `raw_data` into lane `lane_idx` and increments `byte_cnt` and `lane_idx` (mod 4).
    - Default order is big-endian: the first byte goes to `[31:24]`.
    - When lane 3 is written, the word `{pack[31:8], raw_data}` is pushed into the FIFO in the same cycle. The FIFO write takes effect next edge.
    - When `byte_cnt` reaches FRAME_BYTES, or `flush` is asserted -> PAD.
  - PAD:
    - If `lane_idx`≠0, the unfilled lanes are set to PAD_BYTE and the word is pushed (one cycle). Otherwise no push.
    - Then -> DRAIN.
    - `en` is ignored; a byte arriving here is neither counted nor stored.
  - DRAIN: waits for the FIFO to empty. On the cycle the last word transfers, -> IDLE and `frame_done` pulses 1 on the following cycle.
- Pipeline latency: a 4th byte on `en` at cycle N gives `word_valid`=1 at cycle N+1, assuming the FIFO was empty.
- FIFO full at push time: the word is dropped, `overflow` sets and holds until the next `start`. `byte_cnt` still counts the bytes.
- Simultaneous FIFO push and pop while full: the pop frees the slot, so the push succeeds with no overflow.
- `start` outside IDLE: ignored.
- `flush` in IDLE, PAD or DRAIN: ignored.
- `flush` and `en` in the same cycle: the byte is accepted first, then the block enters PAD.
- FRAME_BYTES reached and `flush` in the same cycle: a single PAD pass.
- `word_data` is stable while `word_valid`=1 and `word_ready`=0.
- `byte_cnt` saturates at 16'hFFFF and does not wrap.
- Reset mid-frame: immediate return to IDLE. FIFO contents are discarded and `frame_done` is not pulsed.

Optional Feature:
- Macro: `RAW_BYTE_PACKER_LSB_FIRST_EN`.
- Defined: little-endian packing. The first byte goes to `[7:0]`, the 4th to `[31:24]`, and pad fills the upper lanes.
- Undefined: big-endian as described above.
- FIFO, handshake and counters are identical in both modes.

Test Plan:
- `start`, then `en` with bytes 11,22,33,44 on consecutive cycles, `word_ready`=1 -> one word 32'h11223344, `word_valid` high 1 cycle after the byte 44 strobe.
- FRAME_BYTES=6, bytes A1..A6, `word_ready`=1 -> words 32'hA1A2A3A4 and 32'hA5A60000, `byte_cnt`=6, `frame_done` pulses once after the last transfer.
- `word_ready`=0, 4*(FIFO_DEPTH+1)=36 bytes -> 8 words held, 9th dropped, `overflow`=1, `byte_cnt`=36. Then `word_ready`=1 drains exactly 8 words.
- Bytes 01,02 then `flush` -> word 32'h01020000. A further `en` with byte 03 during DRAIN is ignored and `byte_cnt` stays 2.
- Reset asserted after 3 bytes of a frame -> all outputs 0 immediately, no `frame_done`. A new `start` + 4 bytes yields a clean word.
- With `RAW_BYTE_PACKER_LSB_FIRST_EN` defined, bytes 11,22,33,44 -> 32'h44332211. Bytes 55,66 + `flush` -> 32'h00006655.
